// File: rtl/nv_fifo_rwsp_32x256_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nv_fifo_rwsp_32x256_ctrl
// Description : Valid/ready FIFO controller for an external DEPTH x DW
//               two-port RAM with a registered read address (ram_re) and a
//               registered output (ram_ore). Turns the two-stage RAM read
//               pipeline into a stallable, full-throughput pop interface.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_fifo_rwsp_32x256_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 256
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   fifo_count
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADR_ONE  = AW'(1);

    logic [AW-1:0] wr_adr;
    logic [AW-1:0] rd_adr;
    logic [AW:0]   rd_avail;   // written but not yet address-issued
    logic          s1_vld;     // RAM read address latched and live
    logic          s2_vld;     // RAM output register holds unpopped data
    logic          push;

    // Ready comes from the registered count only, so a same-cycle capture
    // never lets a push into a full FIFO.
    assign wr_prdy = (fifo_count != CNT_FULL);
    assign push    = wr_pvld & wr_prdy;

    assign ram_we  = push;
    assign ram_wa  = wr_adr;
    assign ram_di  = wr_pd;

    // Output register advances when it is empty or being popped; the read
    // address advances only when the latched one is free or being captured.
    assign ram_ore = s1_vld & (~s2_vld | rd_prdy);
    assign ram_re  = (rd_avail != '0) & (~s1_vld | ram_ore);
    assign ram_ra  = rd_adr;

    assign rd_pvld = s2_vld;
    assign rd_pd   = ram_dout;

    // Write address advances on every accepted push, wrapping naturally.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_adr <= '0;
        end else if (push) begin
            wr_adr <= wr_adr + ADR_ONE;
        end
    end

    // Read address advances on every issued RAM read.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_adr <= '0;
        end else if (ram_re) begin
            rd_adr <= rd_adr + ADR_ONE;
        end
    end

    // Entries available for address issue: +1 on push, -1 on read issue.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_avail <= '0;
        end else begin
            case ({push, ram_re})
                2'b10:   rd_avail <= rd_avail + CNT_ONE;
                2'b01:   rd_avail <= rd_avail - CNT_ONE;
                default: rd_avail <= rd_avail;
            endcase
        end
    end

    // Occupancy: a slot is released only once its data is captured by ore.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            fifo_count <= '0;
        end else begin
            case ({push, ram_ore})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Read pipeline stage valids.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= ram_re  | (s1_vld & ~ram_ore);
            s2_vld <= ram_ore | (s2_vld & ~rd_prdy);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nv_fifo_rwsp_32x256_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_fifo_rwsp_32x256_ctrl
// Description : Self-checking bench for nv_fifo_rwsp_32x256_ctrl. Includes a
//               behavioural model of the external RAM and a queue-based
//               FIFO reference checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_fifo_rwsp_32x256_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 256;

    logic          clk;
    logic          rstn;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   fifo_count;

    nv_fifo_rwsp_32x256_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_ore        (ram_ore),
        .ram_dout       (ram_dout),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM: registered read address and registered output.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_q;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q        <= ram_ra;
        if (ram_ore) ram_dout    <= mem[ra_q];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference model: ordered queue of accepted words. Entries held by the
    // controller are all accepted-but-unpopped words except the one already
    // sitting in the RAM output register.
    logic [DW-1:0] q[$];
    int            wr_ptr   = 0;
    int            rd_issue = 0;
    int            n_push   = 0;
    int            n_pop    = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_pd;
    int            exp_cnt;

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            wr_ptr    = 0;
            rd_issue  = 0;
            hold_prev = 1'b0;
            chk("rst_rd_pvld", int'(rd_pvld), 0);
            chk("rst_count", int'(fifo_count), 0);
            chk("rst_wr_prdy", int'(wr_prdy), 1);
        end else begin
            exp_cnt = q.size() - int'(rd_pvld);
            chk("count", int'(fifo_count), exp_cnt);
            chk("wr_prdy", int'(wr_prdy), int'(exp_cnt != DEPTH));
            chk("ram_we", int'(ram_we), int'(wr_pvld && wr_prdy));
            if (ram_we) chk("ram_wa", int'(ram_wa), wr_ptr % DEPTH);
            if (ram_re) begin
                chk("ram_ra", int'(ram_ra), rd_issue % DEPTH);
                chk("re_overrun", int'(rd_issue < wr_ptr), 1);
                rd_issue++;
            end
            if (hold_prev) begin
                chk("stall_pvld", int'(rd_pvld), 1);
                chkw("stall_pd", rd_pd, prev_pd);
            end
            if (rd_pvld) begin
                chk("pop_underflow", int'(q.size() > 0), 1);
                if (q.size() > 0) chkw("rd_pd", rd_pd, q[0]);
            end
            hold_prev = rd_pvld && !rd_prdy;
            prev_pd   = rd_pd;
            if (rd_pvld && rd_prdy && q.size() > 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (wr_pvld && wr_prdy) begin
                q.push_back(wr_pd);
                wr_ptr++;
                n_push++;
            end
        end
    end

    // Single push into an empty FIFO; entered just after a rising edge.
    task automatic latency_check(input logic [DW-1:0] d);
        wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
        @(negedge clk); chk("lat_t_we", int'(ram_we), 1);
        @(posedge clk); #1 wr_pvld = 1'b0;
        @(negedge clk);
        chk("lat_t1_re", int'(ram_re), 1);
        chk("lat_t1_ore", int'(ram_ore), 0);
        chk("lat_t1_pvld", int'(rd_pvld), 0);
        @(negedge clk);
        chk("lat_t2_re", int'(ram_re), 0);
        chk("lat_t2_ore", int'(ram_ore), 1);
        chk("lat_t2_pvld", int'(rd_pvld), 0);
        @(negedge clk);
        chk("lat_t3_pvld", int'(rd_pvld), 1);
        chkw("lat_t3_pd", rd_pd, d);
        @(negedge clk);
        chk("lat_t4_pvld", int'(rd_pvld), 0);
        chk("lat_t4_count", int'(fifo_count), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int ok = 0;
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fifo_count == '0 && !rd_pvld && q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(nm, ok, 1);
        @(posedge clk); #1;
    endtask

    int base;
    int pbase;

    initial begin
        rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
        @(negedge clk);
        chk("reset_we", int'(ram_we), 0);
        chk("reset_re", int'(ram_re), 0);
        chk("reset_ore", int'(ram_ore), 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single word latency
        latency_check({32{8'hA5}});

        // Fill with rd_prdy=0: the output register keeps word 0, so 33 words
        // are accepted before the count reaches DEPTH.
        base = n_push; rd_prdy = 1'b0; wr_pvld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_pd = DW'(n_push - base);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("fill_accepted", n_push - base, 33);
        chk("fill_count", int'(fifo_count), 32);
        chk("fill_wr_prdy", int'(wr_prdy), 0);
        chkw("fill_head", rd_pd, '0);

        // Full with push held and a pop: 32 -> 31 -> 32
        @(posedge clk); #1 rd_prdy = 1'b1; wr_pd = rnd();
        @(negedge clk);
        chk("full_pop_wr_prdy", int'(wr_prdy), 0);
        chk("full_pop_count", int'(fifo_count), 32);
        @(posedge clk); #1 rd_prdy = 1'b0;
        @(negedge clk);
        chk("full_next_count", int'(fifo_count), 31);
        chk("full_next_wr_prdy", int'(wr_prdy), 1);
        @(posedge clk); #1 wr_pvld = 1'b0;
        @(negedge clk);
        chk("full_refill_count", int'(fifo_count), 32);
        @(posedge clk); #1;
        drain("drain_full");

        // Continuous streaming: two words sit between push and capture
        wr_pvld = 1'b1; rd_prdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_pd = rnd();
            @(negedge clk);
            if (i >= 3) begin
                chk("stream_pvld", int'(rd_pvld), 1);
                chk("stream_count", int'(fifo_count), 2);
            end
            @(posedge clk); #1;
        end
        drain("drain_stream");

        // Random traffic, 1000 words
        base = n_push; pbase = n_pop;
        for (int c = 0; c < 20000 && (n_push - base) < 1000; c++) begin
            wr_pvld = 1'($urandom_range(0, 1));
            rd_prdy = 1'($urandom_range(0, 1));
            wr_pd   = rnd();
            @(posedge clk); #1;
        end
        chk("rand_words", int'((n_push - base) >= 1000), 1);
        drain("drain_rand");
        chk("rand_no_loss", n_pop - pbase, n_push - base);

        // Reset with entries held
        rd_prdy = 1'b0; wr_pvld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_pd = rnd();
            @(posedge clk); #1;
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", int'(fifo_count), 9);
        chk("pre_rst_pvld", int'(rd_pvld), 1);
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        chk("async_rst_pvld", int'(rd_pvld), 0);
        chk("async_rst_count", int'(fifo_count), 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        latency_check(rnd());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
